johnson_slot_arbiter: RTL
=========================

JOHNSON_SLOT_ARBITER -- requirements
Module: johnson_slot_arbiter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  one-cycle request to begin slot sequencing.
REQ-004 stop  input  1  one-cycle request to end sequencing at the next wrap.
REQ-005 req  input  4  per-requester access request, level-sensitive.
REQ-006 grant  output  4  registered one-hot (or zero) grant for the current slot.
REQ-007 phase  output  8  registered Johnson counter state.
REQ-008 slot  output  4  decoded slot index 0-15 of phase.
REQ-009 busy  output  1  high in RUN and DRAIN.
REQ-010 err  output  1  one-cycle pulse on illegal phase pattern.

Function
REQ-011 States SHALL be IDLE, RUN and DRAIN, held in a registered FSM.
REQ-012 In RUN and DRAIN, phase SHALL advance once per cycle as a twisted ring: bits shift left and bit0 takes ~bit7. This gives the sequence 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80 hex, then back to 00.
REQ-013 In IDLE, phase SHALL hold 00.
REQ-014 slot SHALL decode combinationally from phase: the number of ones when bit7=0, else 16 minus the number of ones (00=0, FF=8, 80=15).
REQ-015 IDLE->RUN on start=1; the first advance (to 01) SHALL occur on the edge after the transition edge.
REQ-016 RUN->DRAIN on stop=1; RUN and DRAIN SHALL return to IDLE on the edge where phase goes 80->00, so every run completes whole 16-slot frames.
REQ-017 start SHALL be ignored outside IDLE; stop SHALL be ignored in IDLE and DRAIN; start and stop together in IDLE SHALL be treated as start only.
REQ-018 Slot owner SHALL be slot mod 4.
REQ-019 On each edge that produces a new slot s, grant SHALL be registered from req sampled at that edge:
- owner requesting -> grant the owner;
- otherwise apply REQ-029/REQ-030;
- no eligible requester -> 0000.
REQ-020 grant SHALL be at most one-hot and change only at slot boundaries, with latency of one edge from req to grant.
REQ-021 grant SHALL be 0000 in IDLE. In DRAIN it SHALL follow the same rules as RUN until the return to IDLE.
REQ-022 busy SHALL be high exactly when the state is RUN or DRAIN.
REQ-023 While busy, a phase not among the 16 legal codes SHALL:
- pulse err for one cycle;
- force phase to 00 and grant to 0000 on the next edge;
- leave the FSM state unchanged.
REQ-024 err SHALL be 0 in IDLE.

Reset
REQ-025 Reset SHALL immediately force state IDLE, phase 00, grant 0000, err 0 and busy 0, independent of clk.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release, sequencing SHALL restart only on a new start.
REQ-027 The first edge after reset release SHALL be treated as a normal IDLE cycle.

Configuration
REQ-028 Macro SLOT_SKIP_EN SHALL select the slot reassignment policy.
REQ-029 SLOT_SKIP_EN defined: when the owner is not requesting, the slot SHALL go to the first requesting index in order owner+1, owner+2, owner+3 (mod 4).
REQ-030 SLOT_SKIP_EN undefined: when the owner is not requesting, grant SHALL be 0000 (strict TDM).

Verification
REQ-031 Reset, then start pulse with req=1111 -> phase steps 01..80,00 over 16 cycles, slot 1..15,0, grant cycles 0010,0100,1000,0001,...
REQ-032 req=0100 with SLOT_SKIP_EN defined -> grant=0100 in every slot. With it undefined -> grant=0100 only in slots 2,6,10,14, else 0000.
REQ-033 stop pulsed at slot 5 -> state DRAIN, sequencing continues to 80, then IDLE with phase=00, busy=0, grant=0000.
REQ-034 reset asserted at phase=3F -> immediate phase=00, grant=0000, busy=0; no advance after release until start.
REQ-035 Force phase=55 while busy -> err=1 for one cycle, next phase=00, grant=0000, busy stays 1.
REQ-036 start and stop pulsed together in IDLE -> RUN entered, sequencing runs full frames until a later stop.

Source files
------------

// File: rtl/johnson_slot_arbiter.sv
// johnson_slot_arbiter
//   Time-division arbiter for four requesters, sequenced by an 8-bit
//   Johnson (twisted-ring) counter. One frame is 16 slots, and slot s
//   belongs to requester s mod 4.
//
//   Configuration macro: SLOT_SKIP_EN
//     defined   - an idle owner's slot goes to the next requester in
//                 rotating order owner+1, owner+2, owner+3 (work conserving)
//     undefined - an idle owner's slot stays empty (strict TDM)
//
//   Control protocol: start and stop are single-cycle pulses, sampled on
//   the rising clock edge.
//     start - begins sequencing; honoured only in IDLE.
//     stop  - ends sequencing at the next frame wrap; honoured only in RUN.
//   When both are seen in IDLE, start wins.
//   Requests are level-sensitive. req is sampled on the edge that enters a
//   new slot, and the grant for that slot is registered on the same edge.
//
//   state_dbg shows the FSM state so that external checkers can follow it:
//   0 = IDLE, 1 = RUN, 2 = DRAIN.
module johnson_slot_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [7:0] phase,
   output logic [3:0] slot,
   output logic       busy,
   output logic       err,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] phase_q, phase_d;
   logic [3:0] grant_q, grant_d;

   logic [7:0] phase_adv;
   logic       phase_legal;
   logic       at_wrap;

   // Decode a Johnson code to its slot index.
   // While bit7 is clear the slot equals the count of ones; once bit7 is set
   // the ones drain from the bottom, so the slot is 16 minus the count.
   function automatic logic [3:0] slot_of(input logic [7:0] p);
      logic [3:0] ones;
      ones = 4'd0;
      for (int i = 0; i < 8; i++) begin
         ones = ones + {3'b000, p[i]};
      end
      if (p[7]) begin
         slot_of = 4'(5'd16 - {1'b0, ones});
      end else begin
         slot_of = ones;
      end
   endfunction

   // A legal code is one of two forms:
   //   - a run of ones anchored at bit0 (00, 01, 03 .. FF)
   //   - the bitwise inverse of such a run (FF, FE .. 80, 00)
   // x & (x+1) is zero exactly when x is a low-anchored run of ones.
   function automatic logic legal_code(input logic [7:0] p);
      logic [7:0] inv;
      inv = ~p;
      legal_code = ((p & (p + 8'd1)) == 8'd0) ||
                   ((inv & (inv + 8'd1)) == 8'd0);
   endfunction

   // Choose the grant for slot s given the sampled request vector.
   //   - The owner of slot s is s mod 4, and it always wins if it is
   //     requesting.
   //   - With SLOT_SKIP_EN, an idle owner's slot passes to the first
   //     requester after the owner, in rotating order.
   //   - Without it, an idle owner's slot is left unused.
   function automatic logic [3:0] pick_grant(input logic [3:0] s,
                                             input logic [3:0] r);
      logic [1:0] owner;
      logic [3:0] g;
      owner = s[1:0];
      g     = 4'b0000;
      if (r[owner]) begin
         g[owner] = 1'b1;
      end
`ifdef SLOT_SKIP_EN
      else begin
         logic [1:0] idx;
         logic       found;
         found = 1'b0;
         for (int i = 1; i < 4; i++) begin
            idx = owner + 2'(i);
            if (!found && r[idx]) begin
               g[idx] = 1'b1;
               found  = 1'b1;
            end
         end
      end
`endif
      pick_grant = g;
   endfunction

   // Next Johnson code: shift left, and feed the inverted MSB into bit0.
   always_comb begin
      phase_adv = {phase_q[6:0], ~phase_q[7]};
   end

   // Status decode of the current phase.
   always_comb begin
      phase_legal = legal_code(phase_q);
      at_wrap     = (phase_q == 8'h80);
   end

   // Next-state logic for the FSM, the phase counter and the grant.
   //   - IDLE holds phase at 00 and grant at 0000.
   //   - While busy, each edge advances one slot.
   //   - An illegal phase is not advanced: it resyncs to 00 with no grant,
   //     and the FSM stays where it is.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            phase_d = 8'h00;
            grant_d = 4'b0000;
            if (start) begin
               state_d = RUN;
            end
         end
         RUN, DRAIN: begin
            if (!phase_legal) begin
               phase_d = 8'h00;
               grant_d = 4'b0000;
            end else begin
               phase_d = phase_adv;
               grant_d = pick_grant(slot_of(phase_adv), req);
               if (state_q == RUN) begin
                  // A stop seen on the wrap edge ends the run immediately.
                  // Otherwise DRAIN finishes the frame in progress.
                  if (stop) begin
                     state_d = at_wrap ? IDLE : DRAIN;
                  end
               end else if (at_wrap) begin
                  state_d = IDLE;
               end
               if (state_d == IDLE) begin
                  grant_d = 4'b0000;
               end
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = 8'h00;
            grant_d = 4'b0000;
         end
      endcase
   end

   // State, phase and grant registers.
   // Reset is asynchronous and clears everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         phase_q <= 8'h00;
         grant_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         grant_q <= grant_d;
      end
   end

   // Output decode.
   // err comes straight from the registered phase. The resync to 00 on the
   // next edge clears it, so it lasts exactly one cycle.
   always_comb begin
      phase     = phase_q;
      grant     = grant_q;
      slot      = slot_of(phase_q);
      busy      = (state_q != IDLE);
      err       = (state_q != IDLE) && !phase_legal;
      state_dbg = state_q;
   end

endmodule
